// File: rtl/conv_32b_8b.sv
// conv_32b_8b: serializes LANES*BYTE_W-bit words into BYTE_W-bit bytes, MSB byte first, one byte per clk_4f cycle.
// Latency: a word accepted at edge N into an idle block drives its bytes after edges N+1..N+LANES; gap-free back to back.
// Backpressure: ready_in = !HR_full (registered only), so upstream holds data_in while valid_in && !ready_in.
// Optional build macro IDLE_FILL_EN: when defined, idle/reset data_out is the 8'hBC comma filler instead of zero.

module conv_32b_8b #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [LANES*BYTE_W-1:0]   data_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic [BYTE_W-1:0]         data_out,
  output logic                      valid_out
);

  localparam int WORD_W = LANES * BYTE_W;
  localparam int CW     = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SEND  = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

`ifdef IDLE_FILL_EN
  // Comma character keeps the downstream link aligned while no word is in flight.
  localparam logic [BYTE_W-1:0] FILL = BYTE_W'(8'hBC);
`else
  localparam logic [BYTE_W-1:0] FILL = '0;
`endif

  // Shift register (word being sent) and byte counter
  logic [0:0]          state_q,   state_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic [WORD_W-1:0]   sr_q,      sr_d;
  // One-word holding buffer that hides the load turnaround
  logic [WORD_W-1:0]   hr_q,      hr_d;
  logic                hr_full_q, hr_full_d;
  // Registered outputs
  logic [BYTE_W-1:0]   dout_q,    dout_d;
  logic                vout_q,    vout_d;

  logic                load_edge;
  logic                take;
  logic [BYTE_W-1:0]   cur_byte;

  assign ready_in  = !hr_full_q;
  assign data_out  = dout_q;
  assign valid_out = vout_q;

  // A load decision is made when idle or when the last byte of SR is being selected.
  always_comb begin
    load_edge = (state_q == ST_IDLE) || (cnt_q == CNT_LAST);
    take      = valid_in && !hr_full_q;
  end

  // Select byte cnt of SR; byte 0 is the most significant byte of the word.
  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cnt_q == CW'(k)) begin
        cur_byte = sr_q[(LANES-1-k)*BYTE_W +: BYTE_W];
      end
    end
  end

  // Next-state logic: load SR from HR (priority) or straight from the input, else park HR.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    hr_d      = hr_q;
    hr_full_d = hr_full_q;

    if (load_edge) begin
      if (hr_full_q) begin
        // ready_in was low before this edge, so the input is not taken now.
        sr_d      = hr_q;
        hr_full_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_SEND;
      end else if (take) begin
        // HR empty: the word bypasses HR and goes directly into SR.
        sr_d      = data_in;
        cnt_d     = '0;
        state_d   = ST_SEND;
      end else begin
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (take) begin
        hr_d      = data_in;
        hr_full_d = 1'b1;
      end
    end
  end

  // Output stage lags the counter by one edge, so the last byte leaves on the load edge.
  always_comb begin
    vout_d = (state_q == ST_SEND);
    dout_d = (state_q == ST_SEND) ? cur_byte : FILL;
  end

  // State registers; reset discards any partial word in SR and any parked word in HR.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      hr_q      <= '0;
      hr_full_q <= 1'b0;
      dout_q    <= FILL;
      vout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      hr_q      <= hr_d;
      hr_full_q <= hr_full_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
    end
  end

endmodule

// File: tb/tb_conv_32b_8b.sv
// Self-checking bench for conv_32b_8b: table-driven single words, directed multi-cycle sequences,
// and a randomized run against a word/byte schedule model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.

module tb_conv_32b_8b;

  logic        clk_4f;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        valid_out;

`ifdef IDLE_FILL_EN
  localparam logic [7:0] FILL = 8'hBC;
`else
  localparam logic [7:0] FILL = 8'h00;
`endif

  int n_chk;
  int n_fail;

  conv_32b_8b #(.BYTE_W(8), .LANES(4)) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out)
  );

  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, pass the rising edge, then check the registered outputs.
  task automatic step(input logic rst, input logic v, input logic [31:0] d,
                      input logic ev, input logic [7:0] ed, input logic er, input string nm);
    reset    = rst;
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
    chk({nm, ".valid_out"}, {31'd0, valid_out}, {31'd0, ev});
    chk({nm, ".data_out"},  {24'd0, data_out},  {24'd0, ed});
    chk({nm, ".ready_in"},  {31'd0, ready_in},  {31'd0, er});
  endtask

  typedef struct {
    logic [31:0] w;
    logic [7:0]  e0, e1, e2, e3;
    int          gap;
  } vec_t;

  typedef struct {
    int         t;
    logic [7:0] b;
  } exp_t;

  vec_t tbl[5];
  exp_t q[$];

  initial begin
    int   e;
    int   next_free;
    int   last_start;
    int   s;
    int   dens;
    logic acc;
    logic exp_rdy;

    n_chk  = 0;
    n_fail = 0;

    tbl[0] = '{32'hFFDDAA03, 8'hFF, 8'hDD, 8'hAA, 8'h03, 2};
    tbl[1] = '{32'hAABBCCDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 6};
    tbl[2] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01, 1};
    tbl[3] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78, 3};
    tbl[4] = '{32'h00FF00FF, 8'h00, 8'hFF, 8'h00, 8'hFF, 2};

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'd0;
    #2;

    // Reset state
    step(1, 0, 32'd0, 0, FILL, 1, "reset0");
    step(1, 0, 32'd0, 0, FILL, 1, "reset1");

    // Isolated words: one-cycle accept, four bytes after edges N+1..N+4, then idle
    for (int i = 0; i < 5; i++) begin
      step(0, 1, tbl[i].w, 0, FILL, 1, "tbl_accept");
      step(0, 0, 32'd0, 1, tbl[i].e0, 1, "tbl_b0");
      step(0, 0, 32'd0, 1, tbl[i].e1, 1, "tbl_b1");
      step(0, 0, 32'd0, 1, tbl[i].e2, 1, "tbl_b2");
      step(0, 0, 32'd0, 1, tbl[i].e3, 1, "tbl_b3");
      for (int g = 0; g < tbl[i].gap; g++) begin
        step(0, 0, 32'd0, 0, FILL, 1, "tbl_idle");
      end
    end

    // Back-to-back: 8 contiguous bytes, ready_in low while HR is full
    step(0, 1, 32'h01020304, 0, FILL,  1, "b2b_e1");
    step(0, 1, 32'h05060708, 1, 8'h01, 0, "b2b_e2");
    step(0, 0, 32'd0,        1, 8'h02, 0, "b2b_e3");
    step(0, 0, 32'd0,        1, 8'h03, 0, "b2b_e4");
    step(0, 0, 32'd0,        1, 8'h04, 1, "b2b_e5");
    step(0, 0, 32'd0,        1, 8'h05, 1, "b2b_e6");
    step(0, 0, 32'd0,        1, 8'h06, 1, "b2b_e7");
    step(0, 0, 32'd0,        1, 8'h07, 1, "b2b_e8");
    step(0, 0, 32'd0,        1, 8'h08, 1, "b2b_e9");
    step(0, 0, 32'd0,        0, FILL,  1, "b2b_e10");

    // Load-edge collision plus 3-cycle backpressure hold of C
    step(0, 1, 32'hA0A1A2A3, 0, FILL,  1, "col_e1");
    step(0, 1, 32'hB0B1B2B3, 1, 8'hA0, 0, "col_e2");
    step(0, 1, 32'hDEADBEEF, 1, 8'hA1, 0, "col_e3");
    step(0, 1, 32'hDEADBEEF, 1, 8'hA2, 0, "col_e4");
    step(0, 1, 32'hDEADBEEF, 1, 8'hA3, 1, "col_e5");
    step(0, 1, 32'hDEADBEEF, 1, 8'hB0, 0, "col_e6");
    step(0, 0, 32'd0,        1, 8'hB1, 0, "col_e7");
    step(0, 0, 32'd0,        1, 8'hB2, 0, "col_e8");
    step(0, 0, 32'd0,        1, 8'hB3, 1, "col_e9");
    step(0, 0, 32'd0,        1, 8'hDE, 1, "col_e10");
    step(0, 0, 32'd0,        1, 8'hAD, 1, "col_e11");
    step(0, 0, 32'd0,        1, 8'hBE, 1, "col_e12");
    step(0, 0, 32'd0,        1, 8'hEF, 1, "col_e13");
    step(0, 0, 32'd0,        0, FILL,  1, "col_e14");
    step(0, 0, 32'd0,        0, FILL,  1, "col_e15");

    // Reset mid-word with a word parked in HR
    step(0, 1, 32'h11223344, 0, FILL,  1, "rst_e1");
    step(0, 1, 32'h55667788, 1, 8'h11, 0, "rst_e2");
    step(0, 0, 32'd0,        1, 8'h22, 0, "rst_e3");
    step(1, 0, 32'd0,        0, FILL,  1, "rst_e4");
    step(0, 0, 32'd0,        0, FILL,  1, "rst_e5");
    step(0, 1, 32'h99AABBCC, 0, FILL,  1, "rst_e6");
    step(0, 0, 32'd0,        1, 8'h99, 1, "rst_e7");
    step(0, 0, 32'd0,        1, 8'hAA, 1, "rst_e8");
    step(0, 0, 32'd0,        1, 8'hBB, 1, "rst_e9");
    step(0, 0, 32'd0,        1, 8'hCC, 1, "rst_e10");
    step(0, 0, 32'd0,        0, FILL,  1, "rst_e11");
    step(0, 0, 32'd0,        0, FILL,  1, "rst_e12");

    // Randomized run. Model: a word accepted at edge e starts at max(e+1, end of previous word + 1),
    // its bytes appear MSB first on consecutive edges, and ready_in is low exactly while an accepted
    // word is still waiting for its start (i.e. has not yet been moved into the shift register).
    e          = 0;
    next_free  = 0;
    last_start = -100;
    dens       = 50;
    reset      = 1'b0;
    valid_in   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) dens = $urandom_range(5, 100);
      if (!(valid_in && !ready_in)) begin
        valid_in = (i < 2980) && ($urandom_range(0, 99) < dens);
        data_in  = $urandom();
      end
      acc = valid_in && ready_in;
      @(posedge clk_4f);
      #1;
      e++;
      if (acc) begin
        s = (e + 1 > next_free) ? e + 1 : next_free;
        for (int k = 0; k < 4; k++) begin
          q.push_back('{s + k, data_in[31-8*k -: 8]});
        end
        next_free  = s + 4;
        last_start = s;
      end
      exp_rdy = !(last_start > e + 1);
      chk("rnd.ready_in", {31'd0, ready_in}, {31'd0, exp_rdy});
      if (q.size() > 0 && q[0].t == e) begin
        chk("rnd.valid_out", {31'd0, valid_out}, 32'd1);
        chk("rnd.data_out",  {24'd0, data_out},  {24'd0, q[0].b});
        void'(q.pop_front());
      end else begin
        chk("rnd.valid_out", {31'd0, valid_out}, 32'd0);
        chk("rnd.data_out",  {24'd0, data_out},  {24'd0, FILL});
      end
    end
    chk("rnd.drain", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
